// File: rtl/ab_auto_guesser.sv
// ab_auto_guesser: automatic 1A2B player that prunes a candidate mask after each A/B feedback
module ab_auto_guesser #(
   parameter int MAX_TRIES = 10,
   parameter int ATT_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [2:0]       guess0,
   output logic [2:0]       guess1,
   output logic [2:0]       guess2,
   output logic             guess_valid,
   input  logic             guess_ready,
   input  logic             fb_valid,
   input  logic [1:0]       fb_a,
   input  logic [1:0]       fb_b,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [ATT_W-1:0] attempts
);
   typedef enum logic [2:0] {IDLE, OFFER, WAIT_FB, FILTER, DONE, FAIL} state_t;

   function automatic logic [511:0] legal_mask();
      logic [511:0] m;
      logic [8:0]   v;
      m = '0;
      for (int i = 0; i < 512; i++) begin
         v = 9'(i);
         m[i] = (v[2:0] != v[5:3]) && (v[2:0] != v[8:6]) && (v[5:3] != v[8:6]);
      end
      return m;
   endfunction

   function automatic logic [3:0] score(input logic [8:0] c, input logic [8:0] g);
      logic [1:0] a, b;
      a = 2'(c[2:0] == g[2:0]) + 2'(c[5:3] == g[5:3]) + 2'(c[8:6] == g[8:6]);
      b = 2'(c[2:0] == g[5:3] || c[2:0] == g[8:6])
        + 2'(c[5:3] == g[2:0] || c[5:3] == g[8:6])
        + 2'(c[8:6] == g[2:0] || c[8:6] == g[5:3]);
      return {a, b};
   endfunction

   localparam logic [511:0] LEGAL = legal_mask();

   state_t           state_q;
   logic [511:0]     mask_q;
   logic [8:0]       g_q, surv_q;
   logic [9:0]       idx_q;
   logic             found_q, gv_q, busy_q, done_q, fail_q;
   logic [1:0]       fa_q, fb_q;
   logic [ATT_W-1:0] att_q, att_d;
   logic [2:0]       fsum;
   logic             live, cons;

   // saturating attempt increment, feedback sum and per-index filter decision
   always_comb begin
      att_d = &att_q ? att_q : att_q + 1'b1;
      fsum  = {1'b0, fb_a} + {1'b0, fb_b};
      live  = mask_q[idx_q[8:0]];
      cons  = score(idx_q[8:0], g_q) == {fa_q, fb_q};
   end

   // game FSM: offer guess, judge feedback, then one-index-per-cycle mask filter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         mask_q  <= '0;
         g_q     <= '0;
         surv_q  <= '0;
         idx_q   <= '0;
         found_q <= 1'b0;
         fa_q    <= '0;
         fb_q    <= '0;
         att_q   <= '0;
         gv_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE, FAIL: if (start) begin
               mask_q  <= LEGAL;
               g_q     <= 9'd10;
               att_q   <= '0;
               done_q  <= 1'b0;
               fail_q  <= 1'b0;
               gv_q    <= 1'b1;
               busy_q  <= 1'b1;
               state_q <= OFFER;
            end
            OFFER: if (guess_ready) begin
               att_q   <= att_d;
               gv_q    <= 1'b0;
               state_q <= WAIT_FB;
            end
            WAIT_FB: if (fb_valid) begin
               if (fsum > 3'd3 || (fb_a == 2'd2 && fb_b == 2'd1)) begin
                  fail_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= FAIL;
               end else if (fb_a == 2'd3) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= DONE;
               end else if (att_q == ATT_W'(MAX_TRIES)) begin
                  fail_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= FAIL;
               end else begin
                  fa_q        <= fb_a;
                  fb_q        <= fb_b;
                  mask_q[g_q] <= 1'b0;
                  idx_q       <= '0;
                  found_q     <= 1'b0;
                  state_q     <= FILTER;
               end
            end
            FILTER: if (idx_q[9]) begin
               if (found_q) begin
                  g_q     <= surv_q;
                  gv_q    <= 1'b1;
                  state_q <= OFFER;
               end else begin
                  fail_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= FAIL;
               end
            end else begin
               if (live && !cons) mask_q[idx_q[8:0]] <= 1'b0;
               if (live && cons && !found_q) begin
                  surv_q  <= idx_q[8:0];
                  found_q <= 1'b1;
               end
               idx_q <= idx_q + 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign guess0      = g_q[2:0];
   assign guess1      = g_q[5:3];
   assign guess2      = g_q[8:6];
   assign guess_valid = gv_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign fail        = fail_q;
   assign attempts    = att_q;
endmodule

// File: tb/tb_ab_auto_guesser.sv
// tb_ab_auto_guesser: table-driven first-feedback vectors plus hand sequences for the guesser
module tb_ab_auto_guesser;
   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, guess_ready = 1'b0, fb_valid = 1'b0;
   logic [1:0] fb_a = 2'd0, fb_b = 2'd0;
   logic [2:0] g0, g1, g2, h0, h1, h2;
   logic       gv, busy, done, fail, gv2, busy2, done2, fail2;
   logic [3:0] att, att2;
   int         tests = 0, fails = 0;

   typedef struct {
      logic [1:0] a;
      logic [1:0] b;
      int         kind;
      int         e0;
      int         e1;
      int         e2;
   } vec_t;
   vec_t v [10];

   ab_auto_guesser dut (
      .clk(clk), .rst(rst_n), .start(start),
      .guess0(g0), .guess1(g1), .guess2(g2),
      .guess_valid(gv), .guess_ready(guess_ready),
      .fb_valid(fb_valid), .fb_a(fb_a), .fb_b(fb_b),
      .busy(busy), .done(done), .fail(fail), .attempts(att)
   );

   ab_auto_guesser #(.MAX_TRIES(1), .ATT_W(4)) dut1 (
      .clk(clk), .rst(rst_n), .start(start),
      .guess0(h0), .guess1(h1), .guess2(h2),
      .guess_valid(gv2), .guess_ready(guess_ready),
      .fb_valid(fb_valid), .fb_a(fb_a), .fb_b(fb_b),
      .busy(busy2), .done(done2), .fail(fail2), .attempts(att2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic handshake();
      @(negedge clk);
      guess_ready = 1'b1;
      @(negedge clk);
      guess_ready = 1'b0;
   endtask

   task automatic send_fb(input logic [1:0] a, input logic [1:0] b);
      @(negedge clk);
      fb_valid = 1'b1;
      fb_a = a;
      fb_b = b;
      @(negedge clk);
      fb_valid = 1'b0;
   endtask

   task automatic wait_out(output int cyc);
      cyc = 0;
      while (!(gv || done || fail) && cyc < 700) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   function automatic int gidx();
      return {23'd0, g2, g1, g0};
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc, bad, lat, eg;
      v[0] = '{2'd3, 2'd0, 0, 2, 1, 0};
      v[1] = '{2'd2, 2'd1, 1, 2, 1, 0};
      v[2] = '{2'd3, 2'd1, 1, 2, 1, 0};
      v[3] = '{2'd2, 2'd2, 1, 2, 1, 0};
      v[4] = '{2'd0, 2'd0, 2, 5, 4, 3};
      v[5] = '{2'd1, 2'd1, 2, 3, 2, 0};
      v[6] = '{2'd0, 2'd3, 2, 0, 2, 1};
      v[7] = '{2'd1, 2'd0, 2, 4, 3, 0};
      v[8] = '{2'd2, 2'd0, 2, 3, 1, 0};
      v[9] = '{2'd0, 2'd1, 2, 4, 3, 1};

      repeat (3) @(negedge clk);
      chk("rst_gv", gv, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_fail", fail, 0);
      chk("rst_att", att, 0);
      chk("rst_guess", gidx(), 0);
      rst_n = 1'b1;

      pulse_start();
      chk("start_gv", gv, 1);
      chk("start_guess", gidx(), 10);
      chk("start_att", att, 0);
      chk("start_busy", busy, 1);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         fb_valid = (i == 5);
         @(negedge clk);
         if (!gv || gidx() != 10) bad++;
      end
      fb_valid = 1'b0;
      chk("offer_hold", bad, 0);

      for (int r = 0; r < 10; r++) begin
         pulse_start();
         chk($sformatf("v%0d_start_gv", r), gv, 1);
         chk($sformatf("v%0d_start_guess", r), gidx(), 10);
         handshake();
         chk($sformatf("v%0d_hs_gv", r), gv, 0);
         chk($sformatf("v%0d_hs_att", r), att, 1);
         send_fb(v[r].a, v[r].b);
         chk($sformatf("v%0d_m1_done", r), done2, v[r].kind == 0);
         chk($sformatf("v%0d_m1_fail", r), fail2, v[r].kind != 0);
         chk($sformatf("v%0d_m1_att", r), att2, 1);
         wait_out(cyc);
         lat = (v[r].kind == 2) ? 513 : 0;
         eg = v[r].e2 * 64 + v[r].e1 * 8 + v[r].e0;
         chk($sformatf("v%0d_latency", r), cyc, lat);
         chk($sformatf("v%0d_done", r), done, v[r].kind == 0);
         chk($sformatf("v%0d_fail", r), fail, v[r].kind == 1);
         chk($sformatf("v%0d_busy", r), busy, v[r].kind == 2);
         chk($sformatf("v%0d_guess", r), gidx(), eg);
         chk($sformatf("v%0d_att", r), att, 1);
         if (v[r].kind == 2) begin
            handshake();
            send_fb(2'd3, 2'd0);
            chk($sformatf("v%0d_win_done", r), done, 1);
            chk($sformatf("v%0d_win_att", r), att, 2);
            chk($sformatf("v%0d_win_guess", r), gidx(), eg);
         end
      end

      pulse_start();
      handshake();
      send_fb(2'd1, 2'd1);
      wait_out(cyc);
      chk("contra_lat1", cyc, 513);
      chk("contra_guess1", gidx(), 19);
      handshake();
      send_fb(2'd0, 2'd0);
      wait_out(cyc);
      chk("contra_lat2", cyc, 513);
      chk("contra_fail", fail, 1);
      chk("contra_done", done, 0);
      chk("contra_busy", busy, 0);
      chk("contra_att", att, 2);
      chk("contra_guess_kept", gidx(), 19);
      repeat (5) @(negedge clk);
      chk("contra_fail_held", fail, 1);

      pulse_start();
      handshake();
      send_fb(2'd0, 2'd0);
      repeat (100) @(negedge clk);
      pulse_start();
      chk("filter_start_ignored_gv", gv, 0);
      chk("filter_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_gv", gv, 0);
      chk("midrst_att", att, 0);
      chk("midrst_guess", gidx(), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (600) @(negedge clk);
      chk("midrst_stays_idle", {28'd0, gv, busy, done, fail}, 0);
      pulse_start();
      chk("restart_gv", gv, 1);
      chk("restart_guess", gidx(), 10);
      chk("restart_att", att, 0);
      handshake();
      send_fb(2'd0, 2'd0);
      wait_out(cyc);
      chk("restart_lat", cyc, 513);
      chk("restart_guess2", gidx(), 229);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
